// File: rtl/alphasoc_bus_fabric.sv
// Native-memory-bus fabric: one picorv32-style master to NUM_SLAVES mask/base windows,
// with registered request/response, unmapped-error response, wait-state watchdog and sticky error status.
module alphasoc_bus_fabric #(
   parameter int unsigned                NUM_SLAVES     = 4,
   parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE     = {NUM_SLAVES{32'h0}},
   parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK     = {NUM_SLAVES{32'h0}},
   parameter int unsigned                TIMEOUT_CYCLES = 255,
   parameter logic [31:0]                ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         mem_valid,
   input  logic                         mem_instr,
   input  logic [31:0]                  mem_addr,
   input  logic [31:0]                  mem_wdata,
   input  logic [3:0]                   mem_wstrb,
   output logic                         mem_ready,
   output logic [31:0]                  mem_rdata,
   output logic [NUM_SLAVES-1:0]        s_valid,
   output logic                         s_instr,
   output logic [31:0]                  s_addr,
   output logic [31:0]                  s_wdata,
   output logic [3:0]                   s_wstrb,
   input  logic [NUM_SLAVES-1:0]        s_ready,
   input  logic [NUM_SLAVES*32-1:0]     s_rdata,
   input  logic                         err_clr,
   output logic                         err_irq,
   output logic [1:0]                   err_cause,
   output logic [31:0]                  err_addr
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP,
      ST_ERR
   } state_t;

   state_t                 r_state;
   state_t                 w_next;

   logic [NUM_SLAVES-1:0]  w_hit;
   logic [NUM_SLAVES-1:0]  w_pick;
   logic                   w_any;
   logic                   w_sel_ready;
   logic [31:0]            w_sel_rdata;
   logic                   w_timeout;
   logic                   w_start;
   logic                   w_done;
   logic                   w_unmapped;
   logic                   w_tmo;

   logic [NUM_SLAVES-1:0]  r_s_valid;
   logic                   r_s_instr;
   logic [31:0]            r_s_addr;
   logic [31:0]            r_s_wdata;
   logic [3:0]             r_s_wstrb;
   logic [31:0]            r_rdata;
   logic [CW-1:0]          r_cnt;
   logic [1:0]             r_pend_cause;
   logic [31:0]            r_pend_addr;
   logic                   r_err_irq;
   logic [1:0]             r_err_cause;
   logic [31:0]            r_err_addr;

   // Window decode; the first hit in index order is the only one selected.
   always_comb begin
      w_hit  = '0;
      w_pick = '0;
      w_any  = 1'b0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         w_hit[i] = ((mem_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]);
         if (w_hit[i] && !w_any) begin
            w_pick[i] = 1'b1;
            w_any     = 1'b1;
         end
      end
   end

   // r_s_valid is one-hot while waiting, so it doubles as the response select.
   always_comb begin
      w_sel_rdata = '0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         if (r_s_valid[i]) w_sel_rdata = w_sel_rdata | s_rdata[32*i +: 32];
      end
   end

   assign w_sel_ready = |(s_ready & r_s_valid);
   assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_start    = 1'b0;
      w_done     = 1'b0;
      w_unmapped = 1'b0;
      w_tmo      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (mem_valid) begin
               if (w_any) begin
                  w_next  = ST_WAIT;
                  w_start = 1'b1;
               end else begin
                  w_next     = ST_ERR;
                  w_unmapped = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (w_sel_ready) begin
               w_next = ST_RESP;
               w_done = 1'b1;
            end else if (w_timeout) begin
               w_next = ST_ERR;
               w_tmo  = 1'b1;
            end
         end
         ST_RESP: w_next = ST_IDLE;
         ST_ERR:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_s_valid    <= '0;
         r_s_instr    <= 1'b0;
         r_s_addr     <= '0;
         r_s_wdata    <= '0;
         r_s_wstrb    <= '0;
         r_rdata      <= '0;
         r_cnt        <= '0;
         r_pend_cause <= '0;
         r_pend_addr  <= '0;
      end else begin
         if (w_start) begin
            r_s_valid <= w_pick;
            r_s_instr <= mem_instr;
            r_s_addr  <= mem_addr;
            r_s_wdata <= mem_wdata;
            r_s_wstrb <= mem_wstrb;
            r_cnt     <= '0;
         end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_done) begin
            r_s_valid <= '0;
            r_rdata   <= w_sel_rdata;
         end
         if (w_tmo) begin
            r_s_valid    <= '0;
            r_rdata      <= ERR_RDATA;
            r_pend_cause <= 2'b10;
            r_pend_addr  <= r_s_addr;
         end
         if (w_unmapped) begin
            r_rdata      <= ERR_RDATA;
            r_pend_cause <= 2'b01;
            r_pend_addr  <= mem_addr;
         end
      end
   end

   // A clear that coincides with a newly logged error yields to the error.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_err_irq   <= 1'b0;
         r_err_cause <= '0;
         r_err_addr  <= '0;
      end else if ((r_state == ST_ERR) && (!r_err_irq || err_clr)) begin
         r_err_irq   <= 1'b1;
         r_err_cause <= r_pend_cause;
         r_err_addr  <= r_pend_addr;
      end else if (err_clr) begin
         r_err_irq   <= 1'b0;
         r_err_cause <= '0;
         r_err_addr  <= '0;
      end
   end

   assign mem_ready = (r_state == ST_RESP) || (r_state == ST_ERR);
   assign mem_rdata = r_rdata;
   assign s_valid   = r_s_valid;
   assign s_instr   = r_s_instr;
   assign s_addr    = r_s_addr;
   assign s_wdata   = r_s_wdata;
   assign s_wstrb   = r_s_wstrb;
   assign err_irq   = r_err_irq;
   assign err_cause = r_err_cause;
   assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_alphasoc_bus_fabric.sv
// Directed bench for alphasoc_bus_fabric: a per-transaction timeline model predicts every output
// each cycle; literal expectations pin the headline scenarios.
module tb_alphasoc_bus_fabric;

   localparam int          NS   = 4;
   localparam int          TMO  = 8;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
   // slave3 overlaps slave2 on 0x02xx_xxxx; slave2 must win there
   localparam logic [NS*32-1:0] P_BASE = {32'h0200_0000, 32'h0200_0000, 32'h1000_0000, 32'h0000_0000};
   localparam logic [NS*32-1:0] P_MASK = {32'hFE00_0000, 32'hFF00_0000, 32'hF000_0000, 32'hFF00_0000};

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              mem_valid = 1'b0;
   logic              mem_instr = 1'b0;
   logic [31:0]       mem_addr = '0;
   logic [31:0]       mem_wdata = '0;
   logic [3:0]        mem_wstrb = '0;
   logic              mem_ready;
   logic [31:0]       mem_rdata;
   logic [NS-1:0]     s_valid;
   logic              s_instr;
   logic [31:0]       s_addr;
   logic [31:0]       s_wdata;
   logic [3:0]        s_wstrb;
   logic [NS-1:0]     s_ready = '0;
   logic [NS*32-1:0]  s_rdata = '0;
   logic              err_clr = 1'b0;
   logic              err_irq;
   logic [1:0]        err_cause;
   logic [31:0]       err_addr;

   alphasoc_bus_fabric #(
      .NUM_SLAVES     (NS),
      .SLAVE_BASE     (P_BASE),
      .SLAVE_MASK     (P_MASK),
      .TIMEOUT_CYCLES (TMO),
      .ERR_RDATA      (ERRD)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .mem_valid (mem_valid),
      .mem_instr (mem_instr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .s_valid   (s_valid),
      .s_instr   (s_instr),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_ready   (s_ready),
      .s_rdata   (s_rdata),
      .err_clr   (err_clr),
      .err_irq   (err_irq),
      .err_cause (err_cause),
      .err_addr  (err_addr)
   );

   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;
   bit          chk_en = 1'b1;

   logic          exp_ready = 1'b0;
   logic [31:0]   exp_rdata = '0;
   logic [NS-1:0] exp_sv    = '0;
   logic          exp_instr = 1'b0;
   logic [31:0]   exp_addr  = '0;
   logic [31:0]   exp_wdata = '0;
   logic [3:0]    exp_wstrb = '0;
   logic          exp_irq   = 1'b0;
   logic [1:0]    exp_cause = '0;
   logic [31:0]   exp_eaddr = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("mem_ready", 32'(mem_ready), 32'(exp_ready));
         chk("mem_rdata", mem_rdata, exp_rdata);
         chk("s_valid",   32'(s_valid),   32'(exp_sv));
         chk("s_instr",   32'(s_instr),   32'(exp_instr));
         chk("s_addr",    s_addr,         exp_addr);
         chk("s_wdata",   s_wdata,        exp_wdata);
         chk("s_wstrb",   32'(s_wstrb),   32'(exp_wstrb));
         chk("err_irq",   32'(err_irq),   32'(exp_irq));
         chk("err_cause", 32'(err_cause), 32'(exp_cause));
         chk("err_addr",  err_addr,       exp_eaddr);
      end
   end

   function automatic int lowest_hit(input logic [31:0] a);
      logic [31:0] b;
      logic [31:0] m;
      for (int i = 0; i < NS; i++) begin
         b = P_BASE[32*i +: 32];
         m = P_MASK[32*i +: 32];
         if ((a & m) == b) return i;
      end
      return -1;
   endfunction

   // Runs one transaction from cycle 0 (request) to the idle cycle after mem_ready.
   // lat = cycle (counted from the first s_valid cycle) in which the selected slave raises ready.
   task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input logic ins, input int lat, input logic [31:0] rd,
                      output int sv_cnt, output logic [NS-1:0] sv_val,
                      output int rdy_cyc, output logic [31:0] rdy_data);
      int          sel;
      bit          hit;
      bit          err;
      int          endc;
      logic [NS-1:0] oh;
      sel  = lowest_hit(a);
      hit  = (sel >= 0);
      err  = !hit || (lat > TMO);
      endc = !hit ? 0 : ((lat <= TMO) ? lat : TMO);
      oh   = hit ? NS'(1 << sel) : '0;
      sv_cnt = 0; sv_val = '0; rdy_cyc = -1; rdy_data = '0;
      for (int c = 0; c <= endc + 2; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         if (c == 0) begin
            mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws; mem_instr = ins;
            for (int j = 0; j < NS; j++) s_rdata[32*j +: 32] = (j == sel) ? rd : (32'h5A00_0000 | 32'(j));
         end
         if (hit && c == 1) begin
            exp_addr = a; exp_wdata = wd; exp_wstrb = ws; exp_instr = ins;
         end
         exp_sv    = (hit && c >= 1 && c <= endc) ? oh : '0;
         exp_ready = (c == endc + 1);
         if (c == endc + 1) exp_rdata = err ? ERRD : rd;
         if (err && c == endc + 2 && !exp_irq) begin
            exp_irq = 1'b1; exp_cause = hit ? 2'b10 : 2'b01; exp_eaddr = a;
         end
         s_ready = '0;
         if (hit && c >= 1 && c <= endc) begin
            s_ready = ~oh;
            if (c == lat) s_ready = s_ready | oh;
         end
         if (c == endc + 2) mem_valid = 1'b0;
         @(negedge clk);
         if (s_valid != '0) begin
            sv_cnt++; sv_val = s_valid;
         end
         if (mem_ready && rdy_cyc < 0) begin
            rdy_cyc = c; rdy_data = mem_rdata;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      exp_irq = 1'b0; exp_cause = '0; exp_eaddr = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int            n, rc;
      logic [NS-1:0] v;
      logic [31:0]   d;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;

      // read from slave 2, ready in its third s_valid cycle
      txn(32'h0200_0008, 32'h0, 4'b0000, 1'b0, 3, 32'h1234_5678, n, v, rc, d);
      chk("rd_sv_cycles", 32'(n), 32'd3);
      chk("rd_sv_value",  32'(v), 32'h4);
      chk("rd_ready_cyc", 32'(rc), 32'd4);
      chk("rd_data",      d, 32'h1234_5678);

      // write to slave 0, ready immediately
      txn(32'h0000_0010, 32'hA5A5_0001, 4'b0011, 1'b0, 1, 32'h0BAD_0000, n, v, rc, d);
      chk("wr_ready_cyc", 32'(rc), 32'd2);
      chk("wr_wdata",     s_wdata, 32'hA5A5_0001);
      chk("wr_wstrb",     32'(s_wstrb), 32'h3);

      // instruction fetch to slave 3 only window
      txn(32'h0300_0004, 32'h0, 4'b0000, 1'b1, 2, 32'hC0DE_0003, n, v, rc, d);
      chk("s3_sv_value",  32'(v), 32'h8);
      chk("s3_instr",     32'(s_instr), 32'h1);

      // overlapping windows: lowest index wins
      txn(32'h0200_1000, 32'h0, 4'b0000, 1'b0, 1, 32'h0000_2222, n, v, rc, d);
      chk("ovl_sv_value", 32'(v), 32'h4);

      // unmapped read
      txn(32'hF000_0000, 32'h0, 4'b0000, 1'b0, 0, 32'h0, n, v, rc, d);
      chk("um_sv_cycles", 32'(n), 32'd0);
      chk("um_ready_cyc", 32'(rc), 32'd1);
      chk("um_data",      d, 32'hDEAD_BEEF);
      chk("um_irq",       32'(err_irq), 32'h1);
      chk("um_cause",     32'(err_cause), 32'h1);
      chk("um_addr",      err_addr, 32'hF000_0000);
      clear_err();
      chk("clr_irq",      32'(err_irq), 32'h0);

      // timeout on slave 1, then a second error before clear
      txn(32'h1000_0020, 32'h0, 4'b0000, 1'b0, 100, 32'h0, n, v, rc, d);
      chk("to_sv_cycles", 32'(n), 32'd8);
      chk("to_ready_cyc", 32'(rc), 32'd9);
      chk("to_data",      d, 32'hDEAD_BEEF);
      chk("to_cause",     32'(err_cause), 32'h2);
      txn(32'h8000_0000, 32'h1111_1111, 4'b1111, 1'b0, 0, 32'h0, n, v, rc, d);
      chk("sticky_addr",  err_addr, 32'h1000_0020);
      chk("sticky_cause", 32'(err_cause), 32'h2);
      clear_err();

      // ready on the timeout cycle wins
      txn(32'h1000_0030, 32'h0, 4'b0000, 1'b0, TMO, 32'h7777_0008, n, v, rc, d);
      chk("edge_ready_cyc", 32'(rc), 32'd9);
      chk("edge_data",      d, 32'h7777_0008);
      chk("edge_irq",       32'(err_irq), 32'h0);

      // log an error so reset has non-zero status to wipe, then reset mid-WAIT
      txn(32'hF000_0100, 32'h0, 4'b0000, 1'b0, 0, 32'h0, n, v, rc, d);
      chk_en = 1'b0;
      mem_valid = 1'b1; mem_addr = 32'h1000_0040; mem_wstrb = 4'b0000; s_ready = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_pre_sv",  32'(s_valid), 32'h2);
      #2;
      resetn = 1'b0;
      #1;
      chk("rst_sv",      32'(s_valid), 32'h0);
      chk("rst_ready",   32'(mem_ready), 32'h0);
      chk("rst_rdata",   mem_rdata, 32'h0);
      chk("rst_saddr",   s_addr, 32'h0);
      chk("rst_irq",     32'(err_irq), 32'h0);
      chk("rst_cause",   32'(err_cause), 32'h0);
      mem_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_no_ready", 32'(mem_ready), 32'h0);
      resetn = 1'b1;
      exp_ready = 1'b0; exp_rdata = '0; exp_sv = '0; exp_instr = 1'b0; exp_addr = '0;
      exp_wdata = '0; exp_wstrb = '0; exp_irq = 1'b0; exp_cause = '0; exp_eaddr = '0;
      @(posedge clk); #1;
      chk_en = 1'b1;

      txn(32'h1000_0044, 32'h0, 4'b0000, 1'b0, 2, 32'hFACE_0001, n, v, rc, d);
      chk("post_rst_ready_cyc", 32'(rc), 32'd3);
      chk("post_rst_data",      d, 32'hFACE_0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
